// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall masks, default
// exception targets, FSM state encoding and the stall-request priority merge.
package pipe_ctrl_pkg;

    // Stall masks, bit order [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [31:0] EXC_VECTOR_DEF    = 32'h0000_0020;
    localparam logic [31:0] ERET_CODE_DEF     = 32'h0000_000e;
    localparam logic [15:0] STALL_TIMEOUT_DEF = 16'd1024;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    // The deepest stage asking for a stall decides the mask, since holding a
    // later stage implies holding everything upstream of it.
    function automatic logic [5:0] stall_merge(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
        logic [5:0] m;
        m = STALL_NONE;
        if (req_mem)     m = STALL_MEM;
        else if (req_ex) m = STALL_EX;
        else if (req_id) m = STALL_ID;
        else if (req_if) m = STALL_IF;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of stall requests, exception inputs and sequencer outputs.
// master = the core side driving requests; slave = pipe_ctrl itself.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        exc_pending;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        wdog_trip;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, exc_pending, stall_cnt, flush_cnt, wdog_trip
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, exc_pending, stall_cnt, flush_cnt, wdog_trip
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module pipe_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Clear has priority over counting; the all-ones value is held forever.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: merges stall requests, takes
// MEM-stage exceptions/ERET (deferring them while MEM is stalled), and keeps
// stall/flush statistics plus a stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter logic [31:0] ERET_CODE     = ERET_CODE_DEF,
    parameter logic [15:0] STALL_TIMEOUT = STALL_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    // Watchdog trips on the edge that would bring the run count to the timeout
    localparam logic [15:0] WDOG_LAST = STALL_TIMEOUT - 16'd1;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_type;
    logic [31:0] take_type;
    logic        take;
    logic        latch_pend;
    logic [5:0]  req_vec;
    logic        stall_any;
    logic        run_clr;
    logic [15:0] run_cnt;
    logic        wdog_q;

    assign req_vec = stall_merge(bus.stallreq_if, bus.stallreq_id,
                                 bus.stallreq_ex, bus.stallreq_mem);

    // FSM state register; reset drops any pending exception.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Exception type captured when it arrives during a MEM stall (data only).
    always_ff @(posedge clk) begin
        if (latch_pend)
            pend_type <= bus.excepttype_i;
    end

    // Next-state and take decision; an exception is taken as soon as MEM is free.
    always_comb begin
        state_nxt  = state;
        take       = 1'b0;
        take_type  = bus.excepttype_i;
        latch_pend = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.excepttype_i != '0) begin
                    if (!bus.stallreq_mem) begin
                        take = 1'b1;
                    end else begin
                        latch_pend = 1'b1;
                        state_nxt  = PEND;
                    end
                end
            end
            PEND: begin
                // Older exception wins; anything on excepttype_i now is ignored.
                take_type = pend_type;
                if (!bus.stallreq_mem) begin
                    take      = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Outputs are forced to their reset values while rst is high so the
    // combinational paths agree with the asynchronously cleared registers.
    assign bus.flush       = take & ~rst;
    assign bus.stall       = (take | rst) ? STALL_NONE : req_vec;
    assign bus.new_pc      = !bus.flush ? 32'h0 :
                             (take_type == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
    assign bus.exc_pending = (state == PEND);
    assign bus.wdog_trip   = wdog_q;

    assign stall_any = |bus.stall;
    assign run_clr   = ~stall_any | bus.flush;

    pipe_ctrl_sat_counter #(.W(32)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (stall_any),
        .cnt (bus.stall_cnt)
    );

    pipe_ctrl_sat_counter #(.W(16)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (bus.flush),
        .cnt (bus.flush_cnt)
    );

    pipe_ctrl_sat_counter #(.W(16)) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_clr),
        .en  (stall_any),
        .cnt (run_cnt)
    );

    // Sticky watchdog flag: set once the stall run reaches STALL_TIMEOUT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wdog_q <= 1'b0;
        else if (stall_any && (run_cnt >= WDOG_LAST))
            wdog_q <= 1'b1;
    end

endmodule
